// File: rtl/mig1_sequencer_if.sv
// Mig1 sequencer control interface.
// Groups the run/halt controls, instruction-memory handshake, decoder flags,
// datapath strobes and status seen by the sequencer.
//   master : sequencer side (drives req/strobes/status, samples controls)
//   slave  : core/top-level side (drives controls and decoder flags)
interface mig1_sequencer_if #(
  parameter int CNT_WIDTH = 32
);
  logic                 run;
  logic                 halt_req;
  logic                 imem_ack;
  logic                 insn_is_branch;
  logic                 insn_is_jump;
  logic                 insn_illegal;
  logic                 imem_req;
  logic                 fe_latch;
  logic                 pc_enable;
  logic                 rf_wr_enable;
  logic [2:0]           state;
  logic [CNT_WIDTH-1:0] retired;
  logic                 halted;
  logic                 fault;

  modport master (
    input  run, halt_req, imem_ack, insn_is_branch, insn_is_jump, insn_illegal,
    output imem_req, fe_latch, pc_enable, rf_wr_enable, state, retired, halted, fault
  );

  modport slave (
    output run, halt_req, imem_ack, insn_is_branch, insn_is_jump, insn_illegal,
    input  imem_req, fe_latch, pc_enable, rf_wr_enable, state, retired, halted, fault
  );
endinterface

// File: rtl/mig1_sequencer.sv
// Mig1 multi-cycle sequencer: walks one instruction through
// fetch/decode/execute/writeback, handshakes with instruction memory, gates
// PC advance, front-end latch and register-file write, counts retirements.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous active-high reset
//   bus   : mig1_sequencer_if.master (controls, imem handshake, strobes, status)
//
// state     | meaning
// ----------+--------------------------------------------------
// IDLE  (0) | waiting for run
// FETCH (1) | imem_req high, waiting for imem_ack (timed)
// DECODE(2) | illegal-instruction check
// EXECUTE(3)| datapath operates, no strobes
// WRITEBACK(4)| PC advance, RF write, retire
// HALTED(5) | stopped at an instruction boundary
// FAULT (6) | sticky until reset (code 7 also reads as fault)
module mig1_sequencer #(
  parameter int FETCH_TIMEOUT = 255,
  parameter int TMR_WIDTH     = 8,
  parameter int CNT_WIDTH     = 32
) (
  input logic              clk,
  input logic              reset,
  mig1_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALTED    = 3'd5,
    S_FAULT     = 3'd6
  } state_t;

  localparam bit                   TMO_EN   = (FETCH_TIMEOUT != 0);
  localparam logic [TMR_WIDTH-1:0] TMO_LAST = TMR_WIDTH'(FETCH_TIMEOUT - 1);

  state_t               state_q;
  logic [TMR_WIDTH-1:0] wait_cnt;
  logic [CNT_WIDTH-1:0] retired_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      wait_cnt  <= '0;
      retired_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.run) begin
            state_q  <= S_FETCH;
            wait_cnt <= '0;
          end
        end
        S_FETCH: begin
          // ack in the limit cycle wins over the timeout
          if (bus.imem_ack)
            state_q <= S_DECODE;
          else if (TMO_EN && (wait_cnt == TMO_LAST))
            state_q <= S_FAULT;
          else
            wait_cnt <= wait_cnt + TMR_WIDTH'(1);
        end
        S_DECODE:  state_q <= bus.insn_illegal ? S_FAULT : S_EXECUTE;
        S_EXECUTE: state_q <= S_WRITEBACK;
        S_WRITEBACK: begin
          retired_q <= retired_q + CNT_WIDTH'(1);
          if (bus.halt_req)
            state_q <= S_HALTED;
          else if (bus.run) begin
            state_q  <= S_FETCH;
            wait_cnt <= '0;
          end else
            state_q <= S_IDLE;
        end
        S_HALTED: begin
          if (!bus.halt_req) begin
            if (bus.run) begin
              state_q  <= S_FETCH;
              wait_cnt <= '0;
            end else
              state_q <= S_IDLE;
          end
        end
        S_FAULT: state_q <= S_FAULT;
        default: state_q <= S_FAULT;
      endcase
    end
  end

  // Strobes are combinational but suppressed in a reset cycle so an aborted
  // instruction never advances the PC or writes the register file.
  assign bus.imem_req     = !reset && (state_q == S_FETCH);
  assign bus.fe_latch     = !reset && (state_q == S_FETCH) && bus.imem_ack;
  assign bus.pc_enable    = !reset && (state_q == S_WRITEBACK);
  assign bus.rf_wr_enable = !reset && (state_q == S_WRITEBACK)
                            && !(bus.insn_is_branch || bus.insn_is_jump);

  assign bus.state   = state_q;
  assign bus.retired = retired_q;
  assign bus.halted  = (state_q == S_HALTED);
  assign bus.fault   = (state_q == S_FAULT) || (3'(state_q) == 3'd7);

endmodule
